hex_debug_display: RTL and testbench
====================================

// Module: hex_debug_display
// PURPOSE
//  Multi-channel successor to the fixed 8-digit hex debug readout on the board top level.
//  Captures NUM_CH debug words (MAC stats, sniffer hit counters, MDIO reads) on their valid strobes.
//  Shows one channel at a time on NUM_DIGITS seven-segment digits.
//  Channel is chosen manually (switches) or by timed auto-rotation; a push-button steps channels.
//  Per-channel "updated since last shown" flags drive LEDs.
// PARAMETERS
//  NUM_CH        4           number of debug channels (>=2)
//  NUM_DIGITS    8           digits driven; word width DATA_W = 4*NUM_DIGITS (localparam)
//  DWELL_CYCLES  50_000_000  clk cycles per channel in auto mode (1 s at 50 MHz), >=2
//  ACTIVE_LOW    1           1: segment on = 0 (DE2-115 HEX), 0: segment on = 1
//  CH_W          $clog2(NUM_CH) localparam, channel index width
// PORTS
//  clk         in   1                  system clock
//  rst         in   1                  synchronous reset, active-high
//  ch_data     in   NUM_CH*DATA_W      channel c at [c*DATA_W +: DATA_W]
//  ch_valid    in   NUM_CH             1-cycle capture strobe per channel
//  auto_mode   in   1                  1 = auto-rotate, 0 = manual via sel
//  sel         in   CH_W               manual channel select
//  step        in   1                  button level, active-high, already debounced; rising edge steps
//  freeze      in   1                  1 = ignore ch_valid (hold all captured words)
//  hex_out     out  7*NUM_DIGITS       digit d at [7*d +: 7]; digit 0 = nibble [3:0]; bit0=a..bit6=g
//  cur_ch      out  CH_W               channel currently displayed
//  upd_flag    out  NUM_CH             sticky: channel captured new data since last displayed
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge):
//   - all capture regs = 0; cur_ch = 0; dwell counter = 0; upd_flag = 0; step edge reg = 0.
//   - hex_out = all digits showing "0" (7'b1000000 per digit when ACTIVE_LOW=1).
//   - Reset mid-rotation or mid-capture discards everything; no partial state survives.
//  Capture: cap[c] <= ch_data slice when ch_valid[c] && !freeze. Simultaneous valids all capture.
//  Display path: hex_out registered from cap[cur_ch].
//   - Latency ch_valid -> hex_out change = 2 cycles for the displayed channel.
//   - Latency cur_ch change -> hex_out = 1 cycle.
//  Encoding: full hex 0-F: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
//   - Values are active-high segment patterns; invert all 7 bits when ACTIVE_LOW=1.
//  Step edge: step_q <= step; step_rise = step & ~step_q.
//  Channel select FSM (states MANUAL, AUTO; state = auto_mode registered each cycle):
//   - MANUAL:
//     - step_rise: cur_ch <= (cur_ch==NUM_CH-1) ? 0 : cur_ch+1 (wrap).
//     - else if sel changed since last cycle and sel<NUM_CH: cur_ch <= sel.
//     - sel>=NUM_CH: ignored, cur_ch holds.
//     - dwell counter held at 0.
//   - AUTO:
//     - dwell counts 0..DWELL_CYCLES-1; at terminal count cur_ch advances (wrap) and dwell <= 0.
//     - step_rise: advance immediately, dwell <= 0.
//     - step_rise coinciding with terminal count: advance once only.
//   - MANUAL->AUTO: dwell <= 0, cur_ch unchanged.
//   - AUTO->MANUAL: cur_ch unchanged until the next sel change or step.
//  Update flags, per channel c:
//   - set when captured and c != cur_ch.
//   - cleared every cycle c == cur_ch (next-state value of cur_ch).
//   - capture on the displayed channel leaves its flag clear.
//   - freeze=1 blocks setting.
// TESTING
//  1 Reset: rst=1 for 2 cycles -> hex_out=all "0" patterns, cur_ch=0, upd_flag=0.
//  2 Manual capture: auto_mode=0, sel=0; ch_valid[0] with data 32'hDEADBEEF
//    -> 2 cycles later hex_out digits 7..0 show d,E,A,d,b,E,E,F; upd_flag[0]=0.
//  3 Background flag: sel=0; ch_valid[2] with data 32'h12345678 -> upd_flag[2]=1.
//    Then sel=2 -> cur_ch=2 next cycle, upd_flag[2]=0, display 12345678 one cycle later.
//  4 Auto rotation: DWELL_CYCLES=4, auto_mode=1 -> cur_ch sequence 0,1,2,3,0 changing every 4 cycles.
//    step pulse mid-dwell -> immediate advance, counter restarts; step at terminal count -> single advance.
//  5 Freeze: freeze=1, ch_valid[0] with 32'h0000_0001 -> cap and display unchanged, upd_flag[0] unchanged.
//    freeze=0 then repeat -> captured.
//  6 Edge cases: sel=NUM_CH (param NUM_CH=3, CH_W=2, sel=3) -> cur_ch holds.
//    All ch_valid high same cycle -> all captured, all non-displayed flags set.
//    rst asserted during auto dwell -> cur_ch=0, dwell=0.

Source files
------------

// File: rtl/hex_debug_display_if.sv
// Capture bus for hex_debug_display: per-channel debug words, their strobes and the freeze control.
// The producer side drives through master; the display consumes through slave.
interface hex_debug_display_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 32
);
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_valid;
  logic                     freeze;

  modport master (output ch_data, ch_valid, freeze);
  modport slave  (input  ch_data, ch_valid, freeze);
endinterface

// File: rtl/hex_debug_display.sv
// Multi-channel hex debug readout: captures NUM_CH words on their strobes and shows one channel
// on seven-segment digits, with manual, button-stepped or timed auto channel selection.
module hex_debug_display #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned DWELL_CYCLES = 50_000_000,
  parameter bit          ACTIVE_LOW   = 1'b1,
  localparam int unsigned DATA_W      = 4 * NUM_DIGITS,
  localparam int unsigned CH_W        = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  hex_debug_display_if.slave      cap_bus,
  input  logic                    auto_mode,
  input  logic [CH_W-1:0]         sel,
  input  logic                    step,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic [CH_W-1:0]         cur_ch,
  output logic [NUM_CH-1:0]       upd_flag
);

  localparam int unsigned DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DW_W-1:0] DwellLast = DW_W'(DWELL_CYCLES - 1);
  localparam logic [CH_W-1:0] ChLast    = CH_W'(NUM_CH - 1);
  localparam logic [6:0]      SegZero   = ACTIVE_LOW ? 7'h40 : 7'h3F;
  localparam logic [7*NUM_DIGITS-1:0] HexZero = {NUM_DIGITS{SegZero}};

  localparam logic [0:0] StManual = 1'b0;
  localparam logic [0:0] StAuto   = 1'b1;

  logic [DATA_W-1:0]       cap_q [NUM_CH];
  logic [DATA_W-1:0]       cap_d [NUM_CH];
  logic [0:0]              state_q, state_d;
  logic [CH_W-1:0]         cur_ch_q, cur_ch_d;
  logic [CH_W-1:0]         sel_q, sel_d;
  logic [DW_W-1:0]         dwell_q, dwell_d;
  logic [NUM_CH-1:0]       upd_q, upd_d;
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
  logic                    step_q, step_d;

  logic                    step_rise;
  logic                    sel_ok;
  logic [CH_W-1:0]         ch_next;
  logic [DATA_W-1:0]       shown_word;

  function automatic logic [6:0] seg_enc(input logic [3:0] nib);
    logic [6:0] p;
    unique case (nib)
      4'h0: p = 7'h3F;
      4'h1: p = 7'h06;
      4'h2: p = 7'h5B;
      4'h3: p = 7'h4F;
      4'h4: p = 7'h66;
      4'h5: p = 7'h6D;
      4'h6: p = 7'h7D;
      4'h7: p = 7'h07;
      4'h8: p = 7'h7F;
      4'h9: p = 7'h6F;
      4'hA: p = 7'h77;
      4'hB: p = 7'h7C;
      4'hC: p = 7'h39;
      4'hD: p = 7'h5E;
      4'hE: p = 7'h79;
      default: p = 7'h71;
    endcase
    return ACTIVE_LOW ? ~p : p;
  endfunction

  // Out-of-range manual selects only exist when NUM_CH is not a power of two.
  if (NUM_CH == (1 << CH_W)) begin : g_sel_full
    assign sel_ok = 1'b1;
  end else begin : g_sel_part
    assign sel_ok = (sel < CH_W'(NUM_CH));
  end

  assign step_d    = step;
  assign sel_d     = sel;
  assign state_d   = auto_mode;
  assign step_rise = step & ~step_q;
  assign ch_next   = (cur_ch_q == ChLast) ? '0 : cur_ch_q + CH_W'(1);

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      cap_d[c] = cap_q[c];
      if (cap_bus.ch_valid[c] && !cap_bus.freeze) begin
        cap_d[c] = cap_bus.ch_data[c*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    cur_ch_d = cur_ch_q;
    dwell_d  = '0;
    if (state_q == StAuto) begin
      // A step landing on the terminal count shares the same single advance.
      if (step_rise || (dwell_q == DwellLast)) begin
        cur_ch_d = ch_next;
      end else begin
        dwell_d = dwell_q + DW_W'(1);
      end
    end else begin
      if (step_rise) begin
        cur_ch_d = ch_next;
      end else if ((sel != sel_q) && sel_ok) begin
        cur_ch_d = sel;
      end
    end
  end

  always_comb begin
    upd_d = upd_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cap_bus.ch_valid[c] && !cap_bus.freeze) begin
        upd_d[c] = 1'b1;
      end
      if (CH_W'(c) == cur_ch_d) begin
        upd_d[c] = 1'b0;
      end
    end
  end

  assign shown_word = cap_q[cur_ch_q];

  always_comb begin
    hex_d = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      hex_d[7*d +: 7] = seg_enc(shown_word[4*d +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cap_q[c] <= '0;
      end
      state_q  <= StManual;
      cur_ch_q <= '0;
      sel_q    <= '0;
      dwell_q  <= '0;
      upd_q    <= '0;
      hex_q    <= HexZero;
      step_q   <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        cap_q[c] <= cap_d[c];
      end
      state_q  <= state_d;
      cur_ch_q <= cur_ch_d;
      sel_q    <= sel_d;
      dwell_q  <= dwell_d;
      upd_q    <= upd_d;
      hex_q    <= hex_d;
      step_q   <= step_d;
    end
  end

  assign hex_out  = hex_q;
  assign cur_ch   = cur_ch_q;
  assign upd_flag = upd_q;

endmodule

// File: tb/tb_hex_debug_display.sv
// Directed bench for hex_debug_display: a 4-channel instance for the main features and a
// 3-channel instance for the out-of-range manual select case.
module tb_hex_debug_display;

  logic        clk = 1'b0;
  logic        rst;
  logic        auto_mode, step, auto3, step3;
  logic [1:0]  sel, sel3;
  logic [55:0] hex_out, hex_out3;
  logic [1:0]  cur_ch, cur_ch3;
  logic [3:0]  upd_flag;
  logic [2:0]  upd_flag3;

  int n_total = 0;
  int n_bad   = 0;

  localparam logic [55:0] HexZero = {8{7'h40}};

  hex_debug_display_if #(.NUM_CH(4), .DATA_W(32)) bus  ();
  hex_debug_display_if #(.NUM_CH(3), .DATA_W(32)) bus3 ();

  hex_debug_display #(
    .NUM_CH(4), .NUM_DIGITS(8), .DWELL_CYCLES(4), .ACTIVE_LOW(1'b1)
  ) u_dut (
    .clk(clk), .rst(rst), .cap_bus(bus.slave), .auto_mode(auto_mode), .sel(sel), .step(step),
    .hex_out(hex_out), .cur_ch(cur_ch), .upd_flag(upd_flag)
  );

  hex_debug_display #(
    .NUM_CH(3), .NUM_DIGITS(8), .DWELL_CYCLES(4), .ACTIVE_LOW(1'b1)
  ) u_dut3 (
    .clk(clk), .rst(rst), .cap_bus(bus3.slave), .auto_mode(auto3), .sel(sel3), .step(step3),
    .hex_out(hex_out3), .cur_ch(cur_ch3), .upd_flag(upd_flag3)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'h0: seg = 7'h3F; 4'h1: seg = 7'h06; 4'h2: seg = 7'h5B; 4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66; 4'h5: seg = 7'h6D; 4'h6: seg = 7'h7D; 4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F; 4'h9: seg = 7'h6F; 4'hA: seg = 7'h77; 4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39; 4'hD: seg = 7'h5E; 4'hE: seg = 7'h79; default: seg = 7'h71;
    endcase
  endfunction

  function automatic logic [55:0] exp_hex(input logic [31:0] w);
    logic [55:0] r;
    for (int d = 0; d < 8; d++) r[7*d +: 7] = ~seg(w[4*d +: 4]);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_total++;
    if (hex_out !== HexZero) begin
      n_bad++; $display("FAIL rst_hex got=%h want=%h", hex_out, HexZero);
    end
    n_total++;
    if (cur_ch !== 2'd0) begin n_bad++; $display("FAIL rst_cur got=%0d want=0", cur_ch); end
    n_total++;
    if (upd_flag !== 4'b0) begin n_bad++; $display("FAIL rst_upd got=%b want=0000", upd_flag); end
    rst = 1'b0;
  endtask

  task automatic test_manual_capture();
    bus.ch_data[31:0] = 32'hDEADBEEF;
    bus.ch_valid = 4'b0001;
    tick();
    bus.ch_valid = 4'b0000;
    n_total++;
    if (hex_out !== HexZero) begin
      n_bad++; $display("FAIL cap_lat1 got=%h want=%h", hex_out, HexZero);
    end
    tick();
    n_total++;
    if (hex_out !== exp_hex(32'hDEADBEEF)) begin
      n_bad++; $display("FAIL cap_hex got=%h want=%h", hex_out, exp_hex(32'hDEADBEEF));
    end
    n_total++;
    if (upd_flag !== 4'b0000) begin n_bad++; $display("FAIL cap_upd got=%b want=0000", upd_flag); end
  endtask

  task automatic test_background_flag();
    bus.ch_data[64 +: 32] = 32'h12345678;
    bus.ch_valid = 4'b0100;
    tick();
    bus.ch_valid = 4'b0000;
    n_total++;
    if (upd_flag !== 4'b0100) begin n_bad++; $display("FAIL bg_upd got=%b want=0100", upd_flag); end
    n_total++;
    if (hex_out !== exp_hex(32'hDEADBEEF)) begin
      n_bad++; $display("FAIL bg_hold got=%h want=%h", hex_out, exp_hex(32'hDEADBEEF));
    end
    sel = 2'd2;
    tick();
    n_total++;
    if (cur_ch !== 2'd2) begin n_bad++; $display("FAIL bg_cur got=%0d want=2", cur_ch); end
    n_total++;
    if (upd_flag !== 4'b0000) begin n_bad++; $display("FAIL bg_clr got=%b want=0000", upd_flag); end
    n_total++;
    if (hex_out !== exp_hex(32'hDEADBEEF)) begin
      n_bad++; $display("FAIL bg_lat got=%h want=%h", hex_out, exp_hex(32'hDEADBEEF));
    end
    tick();
    n_total++;
    if (hex_out !== exp_hex(32'h12345678)) begin
      n_bad++; $display("FAIL bg_hex got=%h want=%h", hex_out, exp_hex(32'h12345678));
    end
  endtask

  task automatic test_auto_rotation();
    logic [1:0] want;
    sel = 2'd0;
    tick();
    auto_mode = 1'b1;
    tick();
    for (int k = 1; k <= 16; k++) begin
      tick();
      want = 2'((k / 4) % 4);
      n_total++;
      if (cur_ch !== want) begin
        n_bad++; $display("FAIL auto_seq k=%0d got=%0d want=%0d", k, cur_ch, want);
      end
    end
    tick();
    tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    n_total++;
    if (cur_ch !== 2'd1) begin n_bad++; $display("FAIL step_mid got=%0d want=1", cur_ch); end
    tick(); tick(); tick();
    n_total++;
    if (cur_ch !== 2'd1) begin n_bad++; $display("FAIL step_restart got=%0d want=1", cur_ch); end
    tick();
    n_total++;
    if (cur_ch !== 2'd2) begin n_bad++; $display("FAIL step_dwell got=%0d want=2", cur_ch); end
    tick(); tick(); tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    n_total++;
    if (cur_ch !== 2'd3) begin n_bad++; $display("FAIL step_term got=%0d want=3", cur_ch); end
    tick(); tick(); tick();
    n_total++;
    if (cur_ch !== 2'd3) begin n_bad++; $display("FAIL term_hold got=%0d want=3", cur_ch); end
    tick();
    n_total++;
    if (cur_ch !== 2'd0) begin n_bad++; $display("FAIL term_wrap got=%0d want=0", cur_ch); end
  endtask

  task automatic test_freeze();
    auto_mode = 1'b0;
    tick();
    tick();
    n_total++;
    if (cur_ch !== 2'd0) begin n_bad++; $display("FAIL frz_cur got=%0d want=0", cur_ch); end
    bus.freeze = 1'b1;
    bus.ch_data[31:0]  = 32'h00000001;
    bus.ch_data[63:32] = 32'hCAFEF00D;
    bus.ch_valid = 4'b0011;
    tick();
    bus.ch_valid = 4'b0000;
    tick();
    n_total++;
    if (hex_out !== exp_hex(32'hDEADBEEF)) begin
      n_bad++; $display("FAIL frz_hex got=%h want=%h", hex_out, exp_hex(32'hDEADBEEF));
    end
    n_total++;
    if (upd_flag !== 4'b0000) begin n_bad++; $display("FAIL frz_upd got=%b want=0000", upd_flag); end
    bus.freeze = 1'b0;
    bus.ch_valid = 4'b0011;
    tick();
    bus.ch_valid = 4'b0000;
    n_total++;
    if (upd_flag !== 4'b0010) begin n_bad++; $display("FAIL unfrz_upd got=%b want=0010", upd_flag); end
    tick();
    n_total++;
    if (hex_out !== exp_hex(32'h00000001)) begin
      n_bad++; $display("FAIL unfrz_hex got=%h want=%h", hex_out, exp_hex(32'h00000001));
    end
  endtask

  task automatic test_edge_cases();
    sel3 = 2'd3;
    tick();
    n_total++;
    if (cur_ch3 !== 2'd0) begin n_bad++; $display("FAIL sel_oob got=%0d want=0", cur_ch3); end
    sel3 = 2'd1;
    tick();
    n_total++;
    if (cur_ch3 !== 2'd1) begin n_bad++; $display("FAIL sel3_ok got=%0d want=1", cur_ch3); end
    sel3 = 2'd3;
    tick();
    n_total++;
    if (cur_ch3 !== 2'd1) begin n_bad++; $display("FAIL sel_oob2 got=%0d want=1", cur_ch3); end

    bus.ch_data = {32'h89ABCDEF, 32'h5A5A5A5A, 32'h13579BDF, 32'h0F0F0F0F};
    bus.ch_valid = 4'b1111;
    tick();
    bus.ch_valid = 4'b0000;
    n_total++;
    if (upd_flag !== 4'b1110) begin n_bad++; $display("FAIL all_upd got=%b want=1110", upd_flag); end
    tick();
    n_total++;
    if (hex_out !== exp_hex(32'h0F0F0F0F)) begin
      n_bad++; $display("FAIL all_hex0 got=%h want=%h", hex_out, exp_hex(32'h0F0F0F0F));
    end
    sel = 2'd3;
    tick();
    n_total++;
    if (upd_flag !== 4'b0110) begin n_bad++; $display("FAIL all_upd3 got=%b want=0110", upd_flag); end
    tick();
    n_total++;
    if (hex_out !== exp_hex(32'h89ABCDEF)) begin
      n_bad++; $display("FAIL all_hex3 got=%h want=%h", hex_out, exp_hex(32'h89ABCDEF));
    end

    auto_mode = 1'b1;
    tick(); tick(); tick();
    rst = 1'b1;
    sel = 2'd0;
    tick();
    rst = 1'b0;
    n_total++;
    if (cur_ch !== 2'd0) begin n_bad++; $display("FAIL rstmid_cur got=%0d want=0", cur_ch); end
    n_total++;
    if (upd_flag !== 4'b0000) begin n_bad++; $display("FAIL rstmid_upd got=%b want=0000", upd_flag); end
    n_total++;
    if (hex_out !== HexZero) begin
      n_bad++; $display("FAIL rstmid_hex got=%h want=%h", hex_out, HexZero);
    end
    tick();
    tick(); tick(); tick();
    n_total++;
    if (cur_ch !== 2'd0) begin n_bad++; $display("FAIL rstmid_dwell got=%0d want=0", cur_ch); end
    tick();
    n_total++;
    if (cur_ch !== 2'd1) begin n_bad++; $display("FAIL rstmid_adv got=%0d want=1", cur_ch); end
  endtask

  initial begin
    rst          = 1'b1;
    auto_mode    = 1'b0;
    step         = 1'b0;
    sel          = 2'd0;
    auto3        = 1'b0;
    step3        = 1'b0;
    sel3         = 2'd0;
    bus.ch_data  = '0;
    bus.ch_valid = '0;
    bus.freeze   = 1'b0;
    bus3.ch_data  = '0;
    bus3.ch_valid = '0;
    bus3.freeze   = 1'b0;

    test_reset();
    test_manual_capture();
    test_background_flag();
    test_auto_rotation();
    test_freeze();
    test_edge_cases();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
